// File: rtl/ram_ctrl.sv
// ram_ctrl: arbiter/sequencer sharing a dual-port 256x8 RAM between
// instruction fetch (8-bit reads) and the load/store unit (8/16-bit,
// little-endian). Port 1 always carries the LSU byte address; port 2 carries
// either the fetch address or the LSU high byte (addr+1) for wide accesses.
// A starvation counter blocks the LSU for one cycle after STARVE_MAX
// consecutive fetch deferrals so fetch always makes progress.
module ram_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  f_req_valid,
   input  logic [ADDR_W-1:0]     f_req_addr,
   output logic                  f_req_ready,
   output logic                  f_rsp_valid,
   output logic [DATA_W-1:0]     f_rsp_data,
   input  logic                  l_req_valid,
   input  logic                  l_req_we,
   input  logic                  l_req_wide,
   input  logic [ADDR_W-1:0]     l_req_addr,
   input  logic [2*DATA_W-1:0]   l_req_wdata,
   output logic                  l_req_ready,
   output logic                  l_rsp_valid,
   output logic [2*DATA_W-1:0]   l_rsp_data,
   output logic                  ram_en,
   output logic [ADDR_W-1:0]     ram_addr_1,
   output logic [ADDR_W-1:0]     ram_addr_2,
   output logic [DATA_W-1:0]     ram_wdata_1,
   output logic [DATA_W-1:0]     ram_wdata_2,
   output logic                  ram_rw_1,
   output logic                  ram_rw_2,
   input  logic [DATA_W-1:0]     ram_rdata_1,
   input  logic [DATA_W-1:0]     ram_rdata_2
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0]    starve_q, starve_d;
   logic [ADDR_W-1:0]   addr1_q, addr2_q;
   logic                f_pend_q, l_pend_q, l_wide_q;
   logic [DATA_W-1:0]   f_data_q, f_data_d;
   logic [2*DATA_W-1:0] l_data_q, l_data_d;

   logic                l_acc, f_acc, hazard;
   logic [ADDR_W-1:0]   l_addr_hi;

   // Arbitration: LSU wins unless fetch has been starved; fetch shares the
   // cycle unless port 2 is taken by a wide access or a same-byte write.
   always_comb begin
      l_acc     = 1'b0;
      f_acc     = 1'b0;
      hazard    = 1'b0;
      l_addr_hi = l_req_addr + ADDR_W'(1);
      starve_d  = starve_q;
      l_acc  = !rst && l_req_valid && (starve_q != STARVE_LIM);
      hazard = l_acc && (l_req_wide ||
               (l_req_we && ((l_req_addr == f_req_addr) ||
                             (l_req_wide && (l_addr_hi == f_req_addr)))));
      f_acc  = !rst && f_req_valid && !hazard;
      if (!f_req_valid || f_acc)
         starve_d = '0;
      else if (starve_q != STARVE_LIM)
         starve_d = starve_q + CNT_W'(1);
   end

   // RAM port drive; an idle port reads with its previous address held.
   always_comb begin
      ram_en      = l_acc || f_acc;
      ram_addr_1  = addr1_q;
      ram_rw_1    = 1'b0;
      ram_wdata_1 = '0;
      ram_addr_2  = addr2_q;
      ram_rw_2    = 1'b0;
      ram_wdata_2 = '0;
      if (l_acc) begin
         ram_addr_1  = l_req_addr;
         ram_rw_1    = l_req_we;
         ram_wdata_1 = l_req_we ? l_req_wdata[DATA_W-1:0] : '0;
      end
      if (l_acc && l_req_wide) begin
         ram_addr_2  = l_addr_hi;
         ram_rw_2    = l_req_we;
         ram_wdata_2 = l_req_we ? l_req_wdata[2*DATA_W-1:DATA_W] : '0;
      end else if (f_acc) begin
         ram_addr_2  = f_req_addr;
      end
   end

   // Response path: RAM read data is only valid in the cycle after issue, so
   // it is passed straight through then and captured to hold afterwards.
   always_comb begin
      f_req_ready = f_acc;
      l_req_ready = l_acc;
      f_rsp_valid = f_pend_q;
      l_rsp_valid = l_pend_q;
      f_data_d    = f_pend_q ? ram_rdata_2 : f_data_q;
      l_data_d    = l_data_q;
      if (l_pend_q)
         l_data_d = {(l_wide_q ? ram_rdata_2 : {DATA_W{1'b0}}), ram_rdata_1};
      f_rsp_data  = f_data_d;
      l_rsp_data  = l_data_d;
   end

   // State: starvation counter, held port addresses, pending reads, rsp data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
         addr1_q  <= '0;
         addr2_q  <= '0;
         f_pend_q <= 1'b0;
         l_pend_q <= 1'b0;
         l_wide_q <= 1'b0;
         f_data_q <= '0;
         l_data_q <= '0;
      end else begin
         starve_q <= starve_d;
         addr1_q  <= ram_addr_1;
         addr2_q  <= ram_addr_2;
         f_pend_q <= f_acc;
         l_pend_q <= l_acc && !l_req_we;
         l_wide_q <= l_acc && l_req_wide;
         f_data_q <= f_data_d;
         l_data_q <= l_data_d;
      end
   end

endmodule
